gray_ptr_counter: RTL
=====================

Name: gray_ptr_counter

Overview:
Parametrised up/down binary counter that keeps a registered Gray-code copy of its value. It is the pointer source for async FIFOs and line buffers in the DVP RX path.
- gray_o is a flop output, so it is glitch-free and safe to cross clock domains.
- Adds load-from-Gray, direction control and wrap flagging.
- An optional 2-FF synchroniser brings a foreign Gray pointer into this domain.

Parameters:
PTR_WIDTH, 4, counter/pointer width in bits; range 2^PTR_WIDTH, power-of-two wrap.
SYNC_STAGES, 2, synchroniser depth (>=2); used only with GRAY_PTR_SYNC_EN.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
inc_i  input  1  increment request
dec_i  input  1  decrement request
load_i  input  1  load request, highest priority
load_gray_i  input  PTR_WIDTH  Gray value to load
bin_o  output  PTR_WIDTH  registered binary count
gray_o  output  PTR_WIDTH  registered Gray count; always gray(bin_o)
gray_nxt_o  output  PTR_WIDTH  combinational Gray of next count (for full/empty lookahead)
wrap_o  output  1  registered one-cycle pulse on wrap
sync_gray_i  input  PTR_WIDTH  foreign-domain Gray pointer (GRAY_PTR_SYNC_EN only)
sync_bin_o  output  PTR_WIDTH  synchronised, binary-converted pointer (GRAY_PTR_SYNC_EN only)

Behaviour:
- Reset (rst_n low, asynchronous): bin_o=0, gray_o=0, wrap_o=0, all sync flops=0. Release is synchronous to the next clk edge.
- Next-value priority per cycle:
  - load_i=1: bin_nxt = gray2bin(load_gray_i).
  - else inc_i=1 and dec_i=0: bin_nxt = bin_o+1, mod 2^PTR_WIDTH.
  - else dec_i=1 and inc_i=0: bin_nxt = bin_o-1, mod 2^PTR_WIDTH.
  - else (none, or inc_i and dec_i together): hold.
- Latency: request at edge N, bin_o and gray_o updated at edge N+1. bin_o and gray_o change in the same cycle.
- gray_nxt_o = bin2gray(bin_nxt), purely combinational.
- Gray conversion: g[k]=b[k]^b[k+1], g[MSB]=b[MSB].
- Binary conversion: b[MSB]=g[MSB], b[k]=b[k+1]^g[k].
- Single-step property: on every inc/dec step gray_o changes in exactly one bit. Load is exempt.
- wrap_o asserts for exactly one cycle, coincident with the updated bin_o, when:
  - an increment moves all-ones to 0, or
  - a decrement moves 0 to all-ones.
- wrap_o is never asserted by a load, even if the loaded value equals the wrapped one.
- Hold cycles: wrap_o=0.
- Reset mid-operation: immediate clear regardless of pending requests. The first request after release is taken normally.
- No internal state machine beyond the count register. Arithmetic is unsigned, width PTR_WIDTH, with no carry-out port.

Optional Feature:
Macro GRAY_PTR_SYNC_EN.
- Defined:
  - sync_gray_i passes through SYNC_STAGES flops clocked by clk, all reset to 0 by rst_n.
  - The last stage is converted to binary and registered into sync_bin_o, one cycle after the last stage.
  - Total latency is SYNC_STAGES+1 cycles.
  - No logic between the sync flops.
- Undefined: sync_gray_i and sync_bin_o are absent from the port list, and no sync flops are inferred.

Decomposition:
- Shared package holds:
  - the bin-to-Gray and Gray-to-bin conversion functions, parametrised on width;
  - a localparam for minimum SYNC_STAGES (2).
- One natural sub-module: gray2bin_converter, combinational and width-parametrised. It is instanced twice: on the load path and after the synchroniser.

Test Plan:
1. Reset then 20 inc pulses, PTR_WIDTH=4 -> bin_o steps 0..15,0..3. gray_o after 5 incs = 0111, after 15 = 1000. wrap_o high only on the 15->0 cycle. Checker confirms one gray bit changes per step.
2. From 0, one dec -> bin_o=15, gray_o=1000, wrap_o=1 for one cycle. Further decs step down 14,13.
3. load_i=1, load_gray_i=1100, with inc_i=1 in the same cycle -> next bin_o=8, gray_o=1100, wrap_o=0. The load wins.
4. inc_i=dec_i=1 for 3 cycles at bin_o=6 -> bin_o holds 6, wrap_o=0. gray_nxt_o=0101 throughout.
5. Assert rst_n low mid-stream asynchronously at bin_o=9, between edges -> outputs go to 0 without a clock edge. Counting resumes from 0 after release.
6. (GRAY_PTR_SYNC_EN, SYNC_STAGES=2) drive sync_gray_i=0111 -> sync_bin_o=5 exactly 3 clk edges later. Gray ramp 0..15 gives a monotonic sync_bin_o.

Source files
------------

// File: rtl/gray_ptr_counter_pkg.sv
// Shared Gray/binary conversion helpers and constants for the Gray pointer counter.
// The converters work on a fixed maximum width; callers zero-extend and truncate to their own width.
package gray_ptr_counter_pkg;

    localparam int MIN_SYNC_STAGES = 2;
    localparam int CONV_MAX_W      = 32;

    typedef logic [CONV_MAX_W-1:0] conv_word_t;

    // Zero upper bits stay zero in both directions, so any width up to CONV_MAX_W converts exactly.
    function automatic conv_word_t bin2gray(input conv_word_t b);
        return b ^ (b >> 1'b1);
    endfunction

    function automatic conv_word_t gray2bin(input conv_word_t g);
        conv_word_t b;
        b[CONV_MAX_W-1] = g[CONV_MAX_W-1];
        for (int k = CONV_MAX_W - 2; k >= 0; k--) begin
            b[k] = b[k+1] ^ g[k];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_ptr_counter_gray2bin.sv
// Combinational, width-parametrised Gray-to-binary converter.
module gray2bin_converter
    import gray_ptr_counter_pkg::*;
#(
    parameter int WIDTH = 4
)
(
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    assign o_bin = WIDTH'(gray2bin(CONV_MAX_W'(i_gray)));

endmodule

// File: rtl/gray_ptr_counter.sv
// Up/down binary pointer counter with a registered Gray copy, Gray load and wrap pulse.
// Optional foreign-pointer synchroniser enabled by defining GRAY_PTR_SYNC_EN.
module gray_ptr_counter
    import gray_ptr_counter_pkg::*;
#(
    parameter int PTR_WIDTH   = 4,
    parameter int SYNC_STAGES = 2
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc_i,
    input  logic                 dec_i,
    input  logic                 load_i,
    input  logic [PTR_WIDTH-1:0] load_gray_i,
    output logic [PTR_WIDTH-1:0] bin_o,
    output logic [PTR_WIDTH-1:0] gray_o,
    output logic [PTR_WIDTH-1:0] gray_nxt_o,
    output logic                 wrap_o
`ifdef GRAY_PTR_SYNC_EN
    ,
    input  logic [PTR_WIDTH-1:0] sync_gray_i,
    output logic [PTR_WIDTH-1:0] sync_bin_o
`endif
);

    localparam logic [PTR_WIDTH-1:0] ALL_ONES = {PTR_WIDTH{1'b1}};
    localparam logic [PTR_WIDTH-1:0] ZERO     = {PTR_WIDTH{1'b0}};
    localparam logic [PTR_WIDTH-1:0] ONE      = {{(PTR_WIDTH-1){1'b0}}, 1'b1};

    logic [PTR_WIDTH-1:0] r_bin;
    logic [PTR_WIDTH-1:0] r_gray;
    logic                 r_wrap;
    logic [PTR_WIDTH-1:0] w_load_bin;
    logic [PTR_WIDTH-1:0] w_bin_nxt;
    logic [PTR_WIDTH-1:0] w_gray_nxt;
    logic                 w_wrap_nxt;

    gray2bin_converter #(.WIDTH(PTR_WIDTH)) u_load_conv (
        .i_gray (load_gray_i),
        .o_bin  (w_load_bin)
    );

    // Next-count selection: load beats inc/dec; inc and dec together cancel to a hold.
    always_comb begin
        w_bin_nxt  = r_bin;
        w_wrap_nxt = 1'b0;
        if (load_i) begin
            w_bin_nxt = w_load_bin;
        end else if (inc_i && !dec_i) begin
            w_bin_nxt  = r_bin + ONE;
            w_wrap_nxt = (r_bin == ALL_ONES);
        end else if (dec_i && !inc_i) begin
            w_bin_nxt  = r_bin - ONE;
            w_wrap_nxt = (r_bin == ZERO);
        end else begin
            w_bin_nxt  = r_bin;
            w_wrap_nxt = 1'b0;
        end
    end

    assign w_gray_nxt = PTR_WIDTH'(bin2gray(CONV_MAX_W'(w_bin_nxt)));

    // Count, Gray copy and wrap pulse all update on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin  <= ZERO;
            r_gray <= ZERO;
            r_wrap <= 1'b0;
        end else begin
            r_bin  <= w_bin_nxt;
            r_gray <= w_gray_nxt;
            r_wrap <= w_wrap_nxt;
        end
    end

    assign bin_o      = r_bin;
    assign gray_o     = r_gray;
    assign gray_nxt_o = w_gray_nxt;
    assign wrap_o     = r_wrap;

`ifdef GRAY_PTR_SYNC_EN
    localparam int SYNC_DEPTH = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;

    logic [PTR_WIDTH-1:0] r_sync [SYNC_DEPTH];
    logic [PTR_WIDTH-1:0] r_sync_bin;
    logic [PTR_WIDTH-1:0] w_sync_bin;

    // Plain flop chain: the foreign Gray value is only decoded after the last stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_DEPTH; i++) begin
                r_sync[i] <= ZERO;
            end
        end else begin
            r_sync[0] <= sync_gray_i;
            for (int i = 1; i < SYNC_DEPTH; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    gray2bin_converter #(.WIDTH(PTR_WIDTH)) u_sync_conv (
        .i_gray (r_sync[SYNC_DEPTH-1]),
        .o_bin  (w_sync_bin)
    );

    // Register the decoded pointer so downstream compare logic sees a clean flop output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_bin <= ZERO;
        end else begin
            r_sync_bin <= w_sync_bin;
        end
    end

    assign sync_bin_o = r_sync_bin;
`endif

endmodule
